// File: rtl/vending_dispense_unit_if.sv
// Command/status bundle between the vending controller and its dispense back-end.
// master = controller side (requests, sensors), slave = dispense unit (drives, status).
interface vending_dispense_unit_if #(
   parameter int STOCK_W = 4
);
   logic               product1;
   logic               product2;
   logic               quarter_out;
   logic               drop_sense;
   logic               coin_sense;
   logic               restock;
   logic               fault_clr;
   logic               motor1;
   logic               motor2;
   logic               coin_gate;
   logic [STOCK_W-1:0] stock1;
   logic [STOCK_W-1:0] stock2;
   logic               empty1;
   logic               empty2;
   logic               busy;
   logic               fault;
   logic               overflow;

   modport master (
      output product1, product2, quarter_out, drop_sense, coin_sense, restock, fault_clr,
      input  motor1, motor2, coin_gate, stock1, stock2, empty1, empty2, busy, fault, overflow
   );

   modport slave (
      input  product1, product2, quarter_out, drop_sense, coin_sense, restock, fault_clr,
      output motor1, motor2, coin_gate, stock1, stock2, empty1, empty2, busy, fault, overflow
   );
endinterface

// File: rtl/vending_dispense_unit.sv
// Queues dispense/refund pulses and runs them one at a time as timed, sensor-confirmed drives.
// Request at t reaches the drive output at t+2; requests are never stalled, pending saturates at 3.
module vending_dispense_unit #(
   parameter int MOTOR_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STOCK_W        = 4,
   parameter int STOCK_INIT     = 15
) (
   input  logic                  clk,
   input  logic                  rnot,
   vending_dispense_unit_if.slave bus
);
   localparam int TMAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0]      T_MOTOR = TW'(MOTOR_CYCLES);
   localparam logic [TW-1:0]      T_WAIT  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]      T_ONE   = TW'(1);
   localparam logic [STOCK_W-1:0] S_INIT  = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] S_ONE   = STOCK_W'(1);

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, FAULT} state_t;
   typedef enum logic [1:0] {ACT_P1, ACT_P2, ACT_Q} act_t;

   state_t             state;
   act_t               act;
   act_t               launch_act;
   logic [TW-1:0]      timer;
   logic               edge_seen;
   logic               drop_q, coin_q;
   logic [1:0]         pend1, pend2, pendq;
   logic [STOCK_W-1:0] stock1, stock2;
   logic               motor1, motor2, coin_gate;
   logic               busy, fault, overflow;

   logic drop_edge, coin_edge, match_edge, done;
   logic sel1, sel2, selq, refund1, refund2, launch;
   logic dec1, dec2, decq;
   logic [1:0] incq;

   // Saturating update; callers never decrement a zero count.
   function automatic logic [1:0] pend_next(input logic [1:0] cnt, input logic [1:0] inc,
                                            input logic dec);
      logic [2:0] sum;
      sum = {1'b0, cnt} + {1'b0, inc} - {2'b00, dec};
      return (sum > 3'd3) ? 2'd3 : sum[1:0];
   endfunction

   assign drop_edge  = bus.drop_sense & ~drop_q;
   assign coin_edge  = bus.coin_sense & ~coin_q;
   assign match_edge = (act == ACT_Q) ? coin_edge : drop_edge;
   assign done       = ((state == DRIVE) && (timer == T_ONE) && (edge_seen || match_edge)) ||
                       ((state == WAIT) && match_edge);

   assign sel1    = (state == IDLE) && (pend1 != 2'd0);
   assign sel2    = (state == IDLE) && (pend1 == 2'd0) && (pend2 != 2'd0);
   assign selq    = (state == IDLE) && (pend1 == 2'd0) && (pend2 == 2'd0) && (pendq != 2'd0);
   assign refund1 = sel1 && (stock1 == '0);
   assign refund2 = sel2 && (stock2 == '0);
   assign launch  = (sel1 && !refund1) || (sel2 && !refund2) || selq;
   assign launch_act = sel1 ? ACT_P1 : (sel2 ? ACT_P2 : ACT_Q);

   assign dec1 = refund1 || (done && (act == ACT_P1));
   assign dec2 = refund2 || (done && (act == ACT_P2));
   assign decq = done && (act == ACT_Q);
   assign incq = {1'b0, bus.quarter_out} + {1'b0, refund1 | refund2};

   always_ff @(posedge clk or negedge rnot) begin
      if (!rnot) begin
         state     <= IDLE;
         act       <= ACT_P1;
         timer     <= '0;
         edge_seen <= 1'b0;
         drop_q    <= 1'b0;
         coin_q    <= 1'b0;
         pend1     <= 2'd0;
         pend2     <= 2'd0;
         pendq     <= 2'd0;
         stock1    <= S_INIT;
         stock2    <= S_INIT;
         motor1    <= 1'b0;
         motor2    <= 1'b0;
         coin_gate <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         drop_q <= bus.drop_sense;
         coin_q <= bus.coin_sense;
         pend1  <= pend_next(pend1, {1'b0, bus.product1}, dec1);
         pend2  <= pend_next(pend2, {1'b0, bus.product2}, dec2);
         pendq  <= pend_next(pendq, incq, decq);
         if ((bus.product1 && pend1 == 2'd3) || (bus.product2 && pend2 == 2'd3) ||
             (bus.quarter_out && pendq == 2'd3))
            overflow <= 1'b1;
         busy <= (state != IDLE) || (pend1 != 2'd0) || (pend2 != 2'd0) || (pendq != 2'd0);

         // Restock overrides any decrement landing in the same cycle.
         if (bus.restock) begin
            stock1 <= S_INIT;
            stock2 <= S_INIT;
         end else begin
            if (done && act == ACT_P1 && stock1 != '0) stock1 <= stock1 - S_ONE;
            if (done && act == ACT_P2 && stock2 != '0) stock2 <= stock2 - S_ONE;
         end

         case (state)
            IDLE: begin
               edge_seen <= 1'b0;
               if (launch) begin
                  act       <= launch_act;
                  timer     <= T_MOTOR;
                  state     <= DRIVE;
                  motor1    <= (launch_act == ACT_P1);
                  motor2    <= (launch_act == ACT_P2);
                  coin_gate <= (launch_act == ACT_Q);
               end
            end
            DRIVE: begin
               if (match_edge) edge_seen <= 1'b1;
               if (timer == T_ONE) begin
                  motor1    <= 1'b0;
                  motor2    <= 1'b0;
                  coin_gate <= 1'b0;
                  if (edge_seen || match_edge) begin
                     state <= IDLE;
                  end else begin
                     timer <= T_WAIT;
                     state <= WAIT;
                  end
               end else begin
                  timer <= timer - T_ONE;
               end
            end
            WAIT: begin
               if (match_edge) begin
                  state <= IDLE;
               end else if (timer == T_ONE) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else begin
                  timer <= timer - T_ONE;
               end
            end
            FAULT: begin
               if (bus.fault_clr) begin
                  state <= IDLE;
                  fault <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.motor1    = motor1;
   assign bus.motor2    = motor2;
   assign bus.coin_gate = coin_gate;
   assign bus.stock1    = stock1;
   assign bus.stock2    = stock2;
   assign bus.empty1    = (stock1 == '0);
   assign bus.empty2    = (stock2 == '0);
   assign bus.busy      = busy;
   assign bus.fault     = fault;
   assign bus.overflow  = overflow;
endmodule

// File: tb/tb_vending_dispense_unit.sv
// Directed bench for vending_dispense_unit: cycle-exact latency, ordering, refund, fault and reset.
module tb_vending_dispense_unit;
   logic        clk  = 1'b0;
   logic        rnot = 1'b0;
   int          compared   = 0;
   int          mismatched = 0;
   int          rise [3] = '{0, 0, 0};
   int          overlap  = 0;
   int          gap_viol = 0;
   logic [31:0] seq      = '0;
   logic [2:0]  drv_now;
   logic [2:0]  drv_prev = 3'b000;
   logic [11:0] mh, bh;
   int          len, n, base_m1, base_m2, base_cg;

   vending_dispense_unit_if #(.STOCK_W(4)) bus ();

   vending_dispense_unit #(
      .MOTOR_CYCLES(8), .TIMEOUT_CYCLES(64), .STOCK_W(4), .STOCK_INIT(15)
   ) dut (
      .clk  (clk),
      .rnot (rnot),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Drive-output observer: rising edges, firing order, one-hot and idle-gap checks.
   always @(posedge clk) begin
      #2;
      drv_now = {bus.coin_gate, bus.motor2, bus.motor1};
      if ($countones(drv_now) > 1) overlap++;
      for (int i = 0; i < 3; i++) begin
         if (drv_now[i] && !drv_prev[i]) begin
            rise[i]++;
            seq = {seq[29:0], 2'(i + 1)};
            if (drv_prev != 3'b000) gap_viol++;
         end
      end
      drv_prev = drv_now;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic drive_of(input int which);
      case (which)
         0:       return bus.motor1;
         1:       return bus.motor2;
         default: return bus.coin_gate;
      endcase
   endfunction

   // Waits for the chosen drive, optionally raises its sensor, returns the high time.
   task automatic serve(input int which, input bit answer, output int hi_len);
      int w;
      w = 0;
      hi_len = 0;
      while (drive_of(which) !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      compared++;
      assert (w < 300) else begin
         mismatched++;
         $error("FAIL serve_wait_%0d: observed no drive after %0d cycles, required drive high", which, w);
      end
      if (answer) begin
         if (which == 2) bus.coin_sense = 1'b1;
         else            bus.drop_sense = 1'b1;
      end
      while (drive_of(which) === 1'b1 && hi_len < 300) begin
         hi_len++;
         @(negedge clk);
      end
      bus.coin_sense = 1'b0;
      bus.drop_sense = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rnot = 1'b0;
      @(negedge clk);
      rnot = 1'b1;
   endtask

   initial begin
      bus.product1 = 0; bus.product2 = 0; bus.quarter_out = 0;
      bus.drop_sense = 0; bus.coin_sense = 0; bus.restock = 0; bus.fault_clr = 0;

      // Reset values
      @(negedge clk);
      chk("rst_motor1", bus.motor1, 0);
      chk("rst_motor2", bus.motor2, 0);
      chk("rst_coin_gate", bus.coin_gate, 0);
      chk("rst_stock1", bus.stock1, 15);
      chk("rst_stock2", bus.stock2, 15);
      chk("rst_empty", {bus.empty2, bus.empty1}, 0);
      chk("rst_status", {bus.busy, bus.fault, bus.overflow}, 0);
      rnot = 1'b1;
      repeat (2) @(negedge clk);

      // Single product1, sensor edge in the third drive cycle
      mh = '0; bh = '0;
      bus.product1 = 1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 1)  bus.product1 = 0;
         if (k == 4)  bus.drop_sense = 1;
         if (k == 10) bus.drop_sense = 0;
         mh[k] = bus.motor1;
         bh[k] = bus.busy;
      end
      chk("t1_motor1_window", mh, 12'h3FC);
      chk("t1_busy_window", bh, 12'h7FC);
      chk("t1_stock1", bus.stock1, 14);
      base_m1 = rise[0];
      repeat (20) @(negedge clk);
      chk("t1_no_repeat", rise[0] - base_m1, 0);

      // All three requests in one cycle
      do_reset();
      bus.product1 = 1; bus.product2 = 1; bus.quarter_out = 1;
      @(negedge clk);
      bus.product1 = 0; bus.product2 = 0; bus.quarter_out = 0;
      serve(0, 1, len); chk("t2_len_motor1", len, 8);
      serve(1, 1, len); chk("t2_len_motor2", len, 8);
      serve(2, 1, len); chk("t2_len_coin", len, 8);
      repeat (5) @(negedge clk);
      chk("t2_order", seq[5:0], 6'b01_10_11);
      chk("t2_stock1", bus.stock1, 14);
      chk("t2_stock2", bus.stock2, 14);
      chk("t2_busy", bus.busy, 0);

      // Drain product2, then one more becomes a refund
      do_reset();
      for (int i = 0; i < 15; i++) begin
         bus.product2 = 1;
         @(negedge clk);
         bus.product2 = 0;
         serve(1, 1, len);
      end
      @(negedge clk);
      chk("t3_stock2_zero", bus.stock2, 0);
      chk("t3_empty2", bus.empty2, 1);
      chk("t3_empty1", bus.empty1, 0);
      base_m2 = rise[1]; base_cg = rise[2];
      bus.product2 = 1;
      @(negedge clk);
      bus.product2 = 0;
      serve(2, 1, len); chk("t3_refund_len", len, 8);
      repeat (10) @(negedge clk);
      chk("t3_motor2_quiet", rise[1] - base_m2, 0);
      chk("t3_refund_count", rise[2] - base_cg, 1);
      chk("t3_stock2_hold", bus.stock2, 0);
      bus.restock = 1;
      @(negedge clk);
      bus.restock = 0;
      chk("t3_restock", bus.stock2, 15);
      chk("t3_empty2_clear", bus.empty2, 0);

      // Unanswered drive times out into FAULT
      do_reset();
      bus.product1 = 1;
      @(negedge clk);
      bus.product1 = 0;
      serve(0, 0, len); chk("t4_len", len, 8);
      repeat (63) @(negedge clk);
      chk("t4_fault_early", bus.fault, 0);
      @(negedge clk);
      chk("t4_fault", bus.fault, 1);
      chk("t4_motor1_off", bus.motor1, 0);

      // Quarter requests pile up while faulted
      base_cg = rise[2];
      for (int i = 0; i < 3; i++) begin
         bus.quarter_out = 1;
         @(negedge clk);
         bus.quarter_out = 0;
      end
      chk("t5_no_ovf_at3", bus.overflow, 0);
      bus.quarter_out = 1;
      @(negedge clk);
      bus.quarter_out = 0;
      chk("t5_overflow", bus.overflow, 1);
      chk("t5_still_fault", bus.fault, 1);
      chk("t5_no_coin_in_fault", rise[2] - base_cg, 0);
      bus.fault_clr = 1;
      @(negedge clk);
      bus.fault_clr = 0;
      chk("t5_fault_clr", bus.fault, 0);
      serve(0, 1, len); chk("t5_retry_len", len, 8);
      for (int i = 0; i < 3; i++) serve(2, 1, len);
      repeat (30) @(negedge clk);
      chk("t5_coin_count", rise[2] - base_cg, 3);
      chk("t5_stock1", bus.stock1, 14);
      chk("t5_fault_low", bus.fault, 0);
      chk("t5_overflow_sticky", bus.overflow, 1);
      chk("t5_busy", bus.busy, 0);

      // Asynchronous reset in the middle of a drive
      bus.product2 = 1; bus.quarter_out = 1;
      @(negedge clk);
      bus.product2 = 0; bus.quarter_out = 0;
      n = 0;
      while (bus.motor2 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_in_drive", bus.motor2, 1);
      #2 rnot = 1'b0;
      #1;
      chk("t6_motor2_async", bus.motor2, 0);
      chk("t6_coin_async", bus.coin_gate, 0);
      chk("t6_stock1", bus.stock1, 15);
      chk("t6_stock2", bus.stock2, 15);
      chk("t6_overflow_clr", bus.overflow, 0);
      chk("t6_busy", bus.busy, 0);
      @(negedge clk);
      rnot = 1'b1;
      base_m1 = rise[0]; base_m2 = rise[1]; base_cg = rise[2];
      repeat (40) @(negedge clk);
      chk("t6_work_dropped", (rise[0] - base_m1) + (rise[1] - base_m2) + (rise[2] - base_cg), 0);

      // Restock in the same cycle as a completion
      bus.product1 = 1;
      @(negedge clk);
      bus.product1 = 0;
      @(negedge clk);
      bus.drop_sense = 1;
      repeat (7) @(negedge clk);
      bus.restock = 1;
      @(negedge clk);
      bus.restock = 0;
      bus.drop_sense = 0;
      chk("t7_restock_wins", bus.stock1, 15);
      chk("t7_motor1_done", bus.motor1, 0);
      repeat (3) @(negedge clk);
      chk("t7_idle", bus.busy, 0);

      chk("one_drive_at_a_time", overlap, 0);
      chk("idle_gap_between_actions", gap_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/vending_dispense_unit.md
Name: vending_dispense_unit

Overview:
Back-end executor for the vending controller's output side. It accepts the controller's single-cycle product1, product2 and quarter_out command pulses. It queues them per type and drives the physical product motors and coin-return gate with timed pulses. It confirms each action against a sensor, tracks stock per product and reports empty, fault and overflow status back to the front panel.

Parameters:
MOTOR_CYCLES, 8, cycles the motor or gate output is held high per action (>=1)
TIMEOUT_CYCLES, 64, cycles to wait for sensor confirmation after the motor pulse ends
STOCK_W, 4, width of each stock counter
STOCK_INIT, 15, stock value loaded at reset and on restock (must fit in STOCK_W)

Ports:
clk  in  1  rising-edge clock
rnot  in  1  asynchronous active-low reset
product1  in  1  dispense-product-1 request, one-cycle pulse
product2  in  1  dispense-product-2 request, one-cycle pulse
quarter_out  in  1  return-one-quarter request, one-cycle pulse
drop_sense  in  1  product-fell sensor, synchronous level
coin_sense  in  1  coin-passed sensor, synchronous level
restock  in  1  one-cycle pulse: reload both stock counters
fault_clr  in  1  one-cycle pulse: leave FAULT and retry
motor1  out  1  product-1 motor drive
motor2  out  1  product-2 motor drive
coin_gate  out  1  coin-return gate drive
stock1  out  STOCK_W  remaining product-1 count
stock2  out  STOCK_W  remaining product-2 count
empty1  out  1  stock1 == 0
empty2  out  1  stock2 == 0
busy  out  1  state != IDLE or any pending count nonzero
fault  out  1  high while in FAULT
overflow  out  1  sticky: a request arrived while its pending count was 3; cleared only by reset

Behaviour:
- Reset (rnot low, async): state IDLE; all pending counts 0. Outputs: motor1/motor2/coin_gate/fault/overflow/busy = 0, stock1 = stock2 = STOCK_INIT, empty1 = empty2 = 0 (STOCK_INIT > 0).
- Reset mid-action drops motor drive immediately and discards all pending work.
- Pending counters: pend1, pend2, pendq, 2 bits each, saturating at 3.
- Each counter increments on its request pulse. All three can increment in the same cycle.
- An increment and a decrement on the same counter in the same cycle leave it unchanged.
- Sensors are edge-detected internally; only a 0->1 transition counts as one confirmation.
- States: IDLE, DRIVE, WAIT, FAULT.
- IDLE selection priority: pend1 > pend2 > pendq.
  - Selected product with stock 0: decrement its pending, increment pendq (refund), stay IDLE for that cycle.
  - Otherwise latch the action type, load the timer with MOTOR_CYCLES and go to DRIVE next cycle.
  - At most one selection per cycle.
- DRIVE:
  - The selected output is high for exactly MOTOR_CYCLES cycles; only one drive output is ever high.
  - The matching sensor is watched from the first DRIVE cycle. drop_sense matches product actions; coin_sense matches coin actions.
  - An edge seen during DRIVE is remembered.
  - At the end of DRIVE: if the edge was remembered, complete; else load the timer with TIMEOUT_CYCLES and go to WAIT.
- WAIT: a matching edge completes the action. If the timer expires first, go to FAULT.
- Complete:
  - Decrement the pending count of that type.
  - For a product action, decrement its stock; stock never wraps below 0.
  - Return to IDLE.
  - At least one IDLE cycle occurs between consecutive actions.
- FAULT:
  - fault = 1 and drives = 0; pending work is kept and new requests still accumulate.
  - fault_clr returns to IDLE, and the same action is reselected by priority.
- Non-matching sensor edges are ignored in every state.
- restock reloads both stocks to STOCK_INIT in any state. It wins over a same-cycle decrement.
- Latency: request pulse at cycle t, unit idle, stock > 0 -> drive high from t+2.

Test Plan:
- Reset, then product1 pulse; drop_sense edge in DRIVE cycle 3 -> motor1 high cycles t+2..t+9; pend1 0; stock1 15->14; busy low at t+11.
- product1, product2 and quarter_out in the same cycle, each sensor answered promptly -> motor1, then motor2, then coin_gate, strictly sequential with an idle gap; stock1 = stock2 = 14.
- 15 serviced product2 requests, then one more -> empty2 = 1; motor2 stays low; one coin_gate pulse (refund); stock2 remains 0.
- product1 with no drop_sense -> after 8 drive + 64 wait cycles fault = 1 and motor1 = 0; fault_clr -> motor1 pulses again; sensor answered -> fault = 0, stock1 = 14.
- Four quarter_out pulses while in FAULT -> pendq saturates at 3 and overflow = 1 (sticky). After fault_clr, exactly 3 coin_gate pulses.
- rnot low mid-DRIVE -> coin_gate/motors drop asynchronously; stocks = 15; pending = 0; no action after rnot returns high. restock same cycle as a completion -> stock = 15.
